// File: rtl/mont_pkg.sv
// Shared types and constants for the bit-serial Montgomery multiplier.
// MONT_FINAL_SUB_EN selects whether the final conditional subtract stage exists.
package mont_pkg;

   localparam int MONT_N_DEFAULT = 512;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      SUB  = 2'd2,
      DONE = 2'd3
   } mont_state_t;

   // Cycles from the accepting edge to the edge on which done is seen high.
   function automatic int mont_latency(input int n, input bit final_sub);
      return final_sub ? n + 2 : n + 1;
   endfunction

endpackage

// File: rtl/montgomery_iter_step.sv
// One radix-2 Montgomery iteration: C' = (C + a*B [+ M]) / 2.
// Kept separate so a carry-save implementation can drop in later.
module montgomery_iter_step
   import mont_pkg::*;
#(
   parameter int N = MONT_N_DEFAULT
) (
   input  logic [N+1:0] c,
   input  logic [N-1:0] b,
   input  logic [N-1:0] m,
   input  logic         a_bit,
   output logic [N+1:0] c_next
);

   logic [N+1:0] t_add;
   logic [N+1:0] t_red;

   // Adding M when T is odd makes T even so the halving is exact modulo M.
   assign t_add  = c + (a_bit ? {2'b00, b} : '0);
   assign t_red  = t_add[0] ? t_add + {2'b00, m} : t_add;
   assign c_next = t_red >> 1;

endmodule

// File: rtl/montgomery_mult_core.sv
// Bit-serial radix-2 Montgomery multiplier: result = A*B*2^-N mod M.
// Build option MONT_FINAL_SUB_EN adds the final conditional-subtract (SUB) state.
module montgomery_mult_core
   import mont_pkg::*;
#(
   parameter int N = MONT_N_DEFAULT
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         start,
   input  logic [N-1:0] in_a,
   input  logic [N-1:0] in_b,
   input  logic [N-1:0] in_m,
   output logic [N:0]   result,
   output logic         done,
   output logic         busy
);

   localparam int             CNT_W = $clog2(N);
   localparam logic [CNT_W-1:0] LAST_I = CNT_W'(N - 1);

   mont_state_t      state;
   mont_state_t      state_next;
   logic [N-1:0]     a_reg;
   logic [N-1:0]     b_reg;
   logic [N-1:0]     m_reg;
   logic [N+1:0]     c_reg;
   logic [N+1:0]     c_step;
   logic [CNT_W-1:0] cnt;
   logic             accept;
   logic             last_iter;

   assign accept    = start && (state == IDLE || state == DONE);
   assign last_iter = (cnt == LAST_I);

   montgomery_iter_step #(.N(N)) u_iter_step (
      .c      (c_reg),
      .b      (b_reg),
      .m      (m_reg),
      .a_bit  (a_reg[0]),
      .c_next (c_step)
   );

   // NOTE: all state uses non-blocking assignments and a synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!resetn) state <= IDLE;
      else         state <= state_next;
   end

   // NOTE: next state defaults to the current state first, so no path can infer a latch.
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE: if (start) state_next = ITER;
         ITER: begin
            if (last_iter) begin
`ifdef MONT_FINAL_SUB_EN
               state_next = SUB;
`else
               state_next = DONE;
`endif
            end
         end
         SUB:  state_next = DONE;
         DONE: state_next = start ? ITER : IDLE;
         default: state_next = IDLE;
      endcase
   end

   // A is consumed LSB first by shifting it right once per iteration.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         a_reg <= '0;
         b_reg <= '0;
         m_reg <= '0;
         c_reg <= '0;
         cnt   <= '0;
      end else if (accept) begin
         a_reg <= in_a;
         b_reg <= in_b;
         m_reg <= in_m;
         c_reg <= '0;
         cnt   <= '0;
      end else if (state == ITER) begin
         c_reg <= c_step;
         a_reg <= a_reg >> 1;
         cnt   <= last_iter ? '0 : cnt + CNT_W'(1);
      end
   end

`ifdef MONT_FINAL_SUB_EN
   logic [N:0] sub_val;
   assign sub_val = c_reg[N:0] - {1'b0, m_reg};

   always_ff @(posedge clk) begin
      if (!resetn)             result <= '0;
      else if (state == SUB)   result <= (c_reg >= {2'b00, m_reg}) ? sub_val : c_reg[N:0];
   end
`else
   // Without the subtract stage the last iteration's output is the result (< 2M).
   always_ff @(posedge clk) begin
      if (!resetn)                        result <= '0;
      else if (state == ITER && last_iter) result <= c_step[N:0];
   end
`endif

   assign done = (state == DONE);
   assign busy = (state == ITER) || (state == SUB);

endmodule

// File: tb/tb_montgomery_mult_core.sv
// Self-checking bench for montgomery_mult_core: N=8 vector table and corner sequences,
// plus randomized N=8 and N=512 runs against an arithmetic reference model.
module tb_montgomery_mult_core;

   typedef logic [1535:0] big_t;

`ifdef MONT_FINAL_SUB_EN
   localparam int EXTRA = 2;
`else
   localparam int EXTRA = 1;
`endif
   localparam int N8    = 8;
   localparam int N512  = 512;
   localparam int LAT8  = N8 + EXTRA;
   localparam int LAT512 = N512 + EXTRA;

   logic             clk = 1'b0;
   logic             resetn;
   logic             s8;
   logic [N8-1:0]    a8, b8, m8;
   logic [N8:0]      r8;
   logic             d8, bz8;
   logic             s5;
   logic [N512-1:0]  a5, b5, m5;
   logic [N512:0]    r5;
   logic             d5, bz5;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   montgomery_mult_core #(.N(N8)) dut8 (
      .clk(clk), .resetn(resetn), .start(s8), .in_a(a8), .in_b(b8), .in_m(m8),
      .result(r8), .done(d8), .busy(bz8)
   );

   montgomery_mult_core #(.N(N512)) dut512 (
      .clk(clk), .resetn(resetn), .start(s5), .in_a(a5), .in_b(b5), .in_m(m5),
      .result(r5), .done(d5), .busy(bz5)
   );

   // Reference: A*B*(2^-1)^n mod M, with 2^-1 mod odd M equal to (M+1)/2.
   function automatic big_t mont_ref(input big_t a, input big_t b, input big_t m, input int n);
      big_t e;
      big_t inv2;
      e    = (a * b) % m;
      inv2 = (m + 1) >> 1;
      for (int i = 0; i < n; i++) e = (e * inv2) % m;
      return e;
   endfunction

   function automatic big_t rand_bits(input int nbits);
      big_t v = '0;
      for (int i = 0; i < 48; i++) v[i*32 +: 32] = $urandom;
      return v & ((big_t'(1) << nbits) - 1);
   endfunction

   task automatic check(input string name, input big_t act, input big_t exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // With the subtract stage the result is exact; without it, congruent and below 2M.
   task automatic check_mont(input string name, input big_t res, input big_t m, input big_t exp);
`ifdef MONT_FINAL_SUB_EN
      check(name, res, exp);
`else
      check({name, "_mod"}, res % m, exp);
      check({name, "_rng"}, big_t'(res < 2 * m), big_t'(1));
`endif
   endtask

   task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] m,
                       output big_t res, output int lat, output int busy_cnt);
      res = '0; lat = 0; busy_cnt = 0;
      @(negedge clk);
      a8 = a; b8 = b; m8 = m; s8 = 1'b1;
      for (int k = 1; k <= LAT8 + 8; k++) begin
         @(negedge clk);
         if (k == 1) s8 = 1'b0;
         if (bz8) busy_cnt++;
         if (d8) begin
            lat = k;
            res = big_t'(r8);
            break;
         end
      end
   endtask

   task automatic run512(input big_t a, input big_t b, input big_t m,
                         output big_t res, output int lat);
      res = '0; lat = 0;
      @(negedge clk);
      a5 = a[N512-1:0]; b5 = b[N512-1:0]; m5 = m[N512-1:0]; s5 = 1'b1;
      for (int k = 1; k <= LAT512 + 8; k++) begin
         @(negedge clk);
         if (k == 1) s5 = 1'b0;
         if (d5) begin
            lat = k;
            res = big_t'(r5);
            break;
         end
      end
   endtask

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] m;
      logic [7:0] exp;
   } vec8_t;

   vec8_t tbl [9];

   initial begin : watchdog
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      big_t res, res2, m, a, b, exp;
      int   lat, lat2, bcnt, n_done, first_k;

      // Expected values for M=239 use 2^-8 mod 239 = 225.
      tbl[0] = '{8'd5,   8'd7,   8'd239, 8'd227};
      tbl[1] = '{8'd1,   8'd17,  8'd239, 8'd1};
      tbl[2] = '{8'd0,   8'd200, 8'd239, 8'd0};
      tbl[3] = '{8'd17,  8'd0,   8'd239, 8'd0};
      tbl[4] = '{8'd238, 8'd238, 8'd239, 8'd225};
      tbl[5] = '{8'd2,   8'd2,   8'd239, 8'd183};
      tbl[6] = '{8'd100, 8'd200, 8'd239, 8'd108};
      tbl[7] = '{8'd1,   8'd1,   8'd239, 8'd225};
      tbl[8] = '{8'd0,   8'd0,   8'd1,   8'd0};

      resetn = 1'b0;
      s8 = 1'b0; a8 = '0; b8 = '0; m8 = '0;
      s5 = 1'b0; a5 = '0; b5 = '0; m5 = '0;
      repeat (3) @(negedge clk);
      check("rst_result8", big_t'(r8), '0);
      check("rst_done8",   big_t'(d8), '0);
      check("rst_busy8",   big_t'(bz8), '0);
      check("rst_result512", big_t'(r5), '0);
      resetn = 1'b1;

      // Single operation: latency, busy window, one-cycle done, held result.
      run8(8'd5, 8'd7, 8'd239, res, lat, bcnt);
      check("c1_latency", big_t'(lat), big_t'(LAT8));
      check("c1_busy_cycles", big_t'(bcnt), big_t'(LAT8 - 1));
      check_mont("c1_result", res, 239, 227);
      @(negedge clk);
      check("c1_done_pulse", big_t'(d8), '0);
      repeat (2) @(negedge clk);
      check_mont("c1_held", big_t'(r8), 239, 227);

      for (int i = 0; i < 9; i++) begin
         run8(tbl[i].a, tbl[i].b, tbl[i].m, res, lat, bcnt);
         check($sformatf("tbl%0d_latency", i), big_t'(lat), big_t'(LAT8));
         check_mont($sformatf("tbl%0d_result", i), res, big_t'(tbl[i].m), big_t'(tbl[i].exp));
      end

      // start during ITER is ignored: one done, first operation's result.
      @(negedge clk);
      a8 = 8'd2; b8 = 8'd2; m8 = 8'd239; s8 = 1'b1;
      n_done = 0; first_k = 0; res = '0;
      for (int k = 1; k <= 2 * LAT8 + 4; k++) begin
         @(negedge clk);
         if (k == 1) s8 = 1'b0;
         if (k == 4) begin a8 = 8'd100; b8 = 8'd200; s8 = 1'b1; end
         if (k == 5) s8 = 1'b0;
         if (d8) begin
            n_done++;
            if (first_k == 0) begin first_k = k; res = big_t'(r8); end
         end
      end
      check("c3_done_count", big_t'(n_done), big_t'(1));
      check("c3_latency", big_t'(first_k), big_t'(LAT8));
      check_mont("c3_result", res, 239, 183);

      // start held during DONE launches the next operation immediately.
      @(negedge clk);
      a8 = 8'd5; b8 = 8'd7; m8 = 8'd239; s8 = 1'b1;
      lat = 0; lat2 = 0; res = '0; res2 = '0;
      for (int k = 1; k <= LAT8 + 8; k++) begin
         @(negedge clk);
         if (k == 1) s8 = 1'b0;
         if (d8) begin
            lat = k; res = big_t'(r8);
            a8 = 8'd1; b8 = 8'd17; s8 = 1'b1;
            break;
         end
      end
      for (int k = 1; k <= LAT8 + 8; k++) begin
         @(negedge clk);
         if (k == 1) s8 = 1'b0;
         if (d8) begin lat2 = k; res2 = big_t'(r8); break; end
      end
      check("c3b_latency1", big_t'(lat), big_t'(LAT8));
      check_mont("c3b_result1", res, 239, 227);
      check("c3b_spacing", big_t'(lat2), big_t'(LAT8));
      check_mont("c3b_result2", res2, 239, 1);

      // Reset mid-iteration aborts: idle, cleared result, no done.
      run8(8'd100, 8'd200, 8'd239, res, lat, bcnt);
      @(negedge clk);
      a8 = 8'd5; b8 = 8'd7; m8 = 8'd239; s8 = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         if (k == 1) s8 = 1'b0;
      end
      resetn = 1'b0;
      @(negedge clk);
      check("c4_busy", big_t'(bz8), '0);
      check("c4_done", big_t'(d8), '0);
      check("c4_result", big_t'(r8), '0);
      resetn = 1'b1;
      n_done = 0;
      for (int k = 1; k <= LAT8 + 4; k++) begin
         @(negedge clk);
         if (d8) n_done++;
      end
      check("c4_no_done", big_t'(n_done), '0);
      run8(8'd100, 8'd200, 8'd239, res, lat, bcnt);
      check("c4_fresh_latency", big_t'(lat), big_t'(LAT8));
      check_mont("c4_fresh_result", res, 239, 108);

      // Randomized N=8: odd M < 128, A,B < M.
      for (int i = 0; i < 150; i++) begin
         m = big_t'(($urandom_range(0, 63) << 1) | 1);
         a = big_t'($urandom_range(0, int'(m) - 1));
         b = big_t'($urandom_range(0, int'(m) - 1));
         exp = mont_ref(a, b, m, N8);
         run8(a[7:0], b[7:0], m[7:0], res, lat, bcnt);
         check($sformatf("r8_%0d_latency", i), big_t'(lat), big_t'(LAT8));
         check_mont($sformatf("r8_%0d_result", i), res, m, exp);
      end

      // Randomized N=512: odd M with MSB clear, A,B < M.
      for (int i = 0; i < 60; i++) begin
         m = rand_bits(N512 - 1) | big_t'(1);
         a = rand_bits(N512) % m;
         b = rand_bits(N512) % m;
         exp = mont_ref(a, b, m, N512);
         run512(a, b, m, res, lat);
         check($sformatf("r512_%0d_latency", i), big_t'(lat), big_t'(LAT512));
         check_mont($sformatf("r512_%0d_result", i), res, m, exp);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
